// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler for several async-FIFO read ports feeding one valid/ready output stage.
// Define FIFO_RD_ARB_BURST_EN to let a source keep the grant for up to BURST consecutive words.
module fifo_rd_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SRC_WIDTH  = 2,
    parameter int unsigned BURST      = 4
) (
    input  logic                          rclk,
    input  logic                          rrst,
    input  logic                          en,
    input  logic [NUM_SRC-1:0]            rempty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] rdata,
    output logic [NUM_SRC-1:0]            rinc,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_WIDTH-1:0]          out_src,
    input  logic                          out_ready,
    output logic                          busy
);

    if (SRC_WIDTH != $clog2(NUM_SRC)) begin : g_bad_src_width
        $error("SRC_WIDTH must equal clog2(NUM_SRC)");
    end
    if (BURST < 1) begin : g_bad_burst
        $error("BURST must be at least 1");
    end

    typedef enum logic {StIdle, StValid} state_e;

    state_e                  state_q, state_d;
    logic [SRC_WIDTH-1:0]    last_q;
    logic [SRC_WIDTH-1:0]    idx;
    logic [SRC_WIDTH-1:0]    cand;
    logic                    cand_found;
    logic [DATA_WIDTH-1:0]   cand_data;
    logic                    load;
    logic                    grant;

`ifdef FIFO_RD_ARB_BURST_EN
    localparam int unsigned BurstW = $clog2(BURST + 1);
    logic [BurstW-1:0] burst_q;
`endif

    assign out_valid = (state_q == StValid);
    assign load      = ~out_valid | out_ready;
    assign busy      = out_valid | (en & ~&rempty);

    // Descending scan so the nearest source after last_q is the one left standing.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        idx        = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = SRC_WIDTH'((int'(last_q) + k) % NUM_SRC);
            if (!rempty[idx]) begin
                cand       = idx;
                cand_found = 1'b1;
            end
        end
`ifdef FIFO_RD_ARB_BURST_EN
        if (burst_q != '0 && burst_q < BurstW'(BURST) && !rempty[last_q]) begin
            cand       = last_q;
            cand_found = 1'b1;
        end
`endif
    end

    always_comb begin
        cand_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand == SRC_WIDTH'(i)) begin
                cand_data = rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant = load & en & cand_found & ~rrst;

    always_comb begin
        rinc = '0;
        if (grant) begin
            rinc[cand] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StValid;
            StValid: if (out_ready) state_d = grant ? StValid : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q  <= StIdle;
            out_data <= '0;
            out_src  <= '0;
            last_q   <= SRC_WIDTH'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            if (grant) begin
                out_data <= cand_data;
                out_src  <= cand;
                last_q   <= cand;
            end
        end
    end

`ifdef FIFO_RD_ARB_BURST_EN
    // Count restarts at 1 on a new source or once a full burst has been served.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            burst_q <= '0;
        end else if (grant) begin
            if (cand != last_q || burst_q >= BurstW'(BURST)) begin
                burst_q <= BurstW'(1);
            end else begin
                burst_q <= burst_q + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
Read-side scheduler for several async-FIFO read ports that share one rclk domain.
- Round-robin arbitration among non-empty FIFOs; issues one-cycle rinc pulses.
- Captures the granted FIFO's read data into a registered valid/ready output stage that feeds a single downstream consumer.
- Sustains one word per cycle when the consumer is always ready.

Parameters:
NUM_SRC, 4, number of FIFO read ports arbitrated (2..8)
DATA_WIDTH, 8, width of each FIFO read word
SRC_WIDTH, 2, width of source index; must equal clog2(NUM_SRC)
BURST, 4, max consecutive grants to one source (used only with FIFO_RD_ARB_BURST_EN)

Ports:
rclk  input  1  read-domain clock; all logic on posedge
rrst  input  1  reset, synchronous, active-high
en  input  1  arbitration enable; low = no new grants
rempty  input  NUM_SRC  bit i high = FIFO i empty (valid in current cycle)
rdata  input  NUM_SRC*DATA_WIDTH  FIFO i word at bits [i*DATA_WIDTH +: DATA_WIDTH]; combinational read of current head
rinc  output  NUM_SRC  one-hot read-increment pulse; FIFO i pops at end of cycle
out_valid  output  1  output word valid
out_data  output  DATA_WIDTH  output word
out_src  output  SRC_WIDTH  index of FIFO that supplied out_data
out_ready  input  1  consumer accepts word when out_valid & out_ready
busy  output  1  high while out_valid or any grant possible (en & ~&rempty)

Behaviour:
- Reset (rrst=1 at posedge): out_valid=0, out_data=0, out_src=0, last-grant pointer = NUM_SRC-1 (first search starts at source 0), FSM=IDLE. rinc is forced to 0 combinationally while rrst=1. Reset mid-transfer drops the held word; no FIFO pops in the reset cycle.
- load = ~out_valid | out_ready.
- Candidate: first i with rempty[i]=0, searched from (last_grant+1) mod NUM_SRC upward with wrap.
- Grant when load & en & candidate exists:
  - rinc[g]=1 (combinational, same cycle), all other rinc bits 0.
  - At posedge: out_data<=rdata[g], out_src<=g, out_valid<=1, last_grant<=g.
- Latency: word visible on out_data one cycle after its rinc pulse.
- No grant and load: out_valid<=0 at posedge; out_data/out_src hold their value.
- Not load (out_valid & ~out_ready): output registers hold, rinc=0, pointer holds.
- en=0: no rinc. A held word stays until accepted, then out_valid drops.
- Simultaneous accept + grant: the new word replaces the old in the same cycle. No bubble, no duplicate.
- Wrap-around: the pointer at NUM_SRC-1 searches from 0 next.
- All FIFOs empty: rinc stays 0, never pulses.
- Invariant: rinc is one-hot or zero. rinc[i] is never high while rempty[i]=1.
- FSM (2 states, encoding free):
  - IDLE (out_valid=0): grant -> VALID; else stay.
  - VALID (out_valid=1): ~out_ready -> stay; out_ready & grant -> VALID; out_ready & no grant -> IDLE.
- busy = out_valid | (en & ~&rempty).

Optional Feature:
Macro FIFO_RD_ARB_BURST_EN.
- Defined:
  - A burst counter (width clog2(BURST+1)) keeps the grant on the current source while it is non-empty and fewer than BURST consecutive grants have been issued.
  - The counter resets to 1 on a grant to a new source and increments on each repeat grant.
  - When the source goes empty or the count reaches BURST, normal round-robin resumes from last_grant+1.
  - rrst clears the counter to 0.
- Undefined: strict single-grant round-robin as above; no counter logic is synthesised.

Test Plan:
- Reset: hold rrst=1 with all FIFOs non-empty for 2 cycles -> rinc=0, out_valid=0, out_data=0, out_src=0. First grant after release goes to source 0.
- Round-robin fairness: NUM_SRC=4, all non-empty, out_ready=1 -> rinc sequence 0001,0010,0100,1000,0001. out_src 0,1,2,3,0 one cycle later. out_valid stays high continuously.
- Backpressure: grant source 2 with data 0xA5, then out_ready=0 for 3 cycles -> out_data holds 0xA5, rinc=0 throughout. On out_ready=1, next grant goes to source 3 in the same cycle.
- Sparse/empty: only source 1 non-empty with 2 words, out_ready=1 -> two rinc[1] pulses, then rinc=0 and out_valid drops one cycle after the last pop. FSM returns to IDLE.
- Enable gating: en=0 with a word held and out_ready=1 -> word accepted, out_valid=0 next cycle, no rinc until en=1.
- Burst (with FIFO_RD_ARB_BURST_EN, BURST=4): sources 0 and 1 each hold 6 words -> out_src 0,0,0,0,1,1,1,1,0,0,1,1.
